clock_sched: RTL

//  Run-time controller for a programmable clock-enable divider. Owns the

---
 rtl/clock_sched_if.sv | 24 ++
 rtl/clock_sched.sv | 124 ++++++++++++
 2 files changed

// File: rtl/clock_sched_if.sv
// Step-configuration handshake bundle for clock_sched.
// master: offers cfg_valid/cfg_step; slave: returns cfg_ready/cfg_err.
interface clock_sched_if #(
    parameter int CNT_W = 26
) ();
    logic             cfg_valid;
    logic [CNT_W-1:0] cfg_step;
    logic             cfg_ready;
    logic             cfg_err;

    modport master (
        output cfg_valid,
        output cfg_step,
        input  cfg_ready,
        input  cfg_err
    );

    modport slave (
        input  cfg_valid,
        input  cfg_step,
        output cfg_ready,
        output cfg_err
    );
endinterface

// File: rtl/clock_sched.sv
// Run-time clock-enable divider: step updates land only on period
// boundaries, with run/stop control and a registered divided output.
// Ports: clk, rst (sync, active high), start, stop, cfg (step
// handshake, slave side), clkout, tick, running.
module clock_sched #(
    parameter int               CNT_W        = 26,
    parameter logic [CNT_W-1:0] DEFAULT_STEP = CNT_W'(50)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          stop,
    clock_sched_if.slave  cfg,
    output logic          clkout,
    output logic          tick,
    output logic          running
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        STOP_PEND
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] step_q, step_d;
    logic [CNT_W-1:0] pend_q, pend_d;
    logic             pvld_q, pvld_d;
    logic             clkout_q, clkout_d;
    logic             tick_q, tick_d;
    logic             run_q, run_d;
    logic             err_q, err_d;

    logic accept;
    logic legal;
    logic boundary;

    // Ready drops only while a step is waiting for its boundary.
    assign cfg.cfg_ready = !pvld_q;
    assign cfg.cfg_err   = err_q;
    assign clkout        = clkout_q;
    assign tick          = tick_q;
    assign running       = run_q;

    assign accept   = cfg.cfg_valid && !pvld_q;
    assign legal    = cfg.cfg_step >= CNT_W'(2);
    assign boundary = cnt_q == (step_q - CNT_W'(1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        step_d  = step_q;
        pend_d  = pend_q;
        pvld_d  = pvld_q;
        err_d   = accept && !legal;

        unique case (state_q)
            IDLE: begin
                if (start && !stop) state_d = RUN;
            end
            RUN: begin
                if (stop) state_d = STOP_PEND;
            end
            STOP_PEND: begin
                if (start)         state_d = RUN;
                else if (boundary) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (state_q == IDLE) begin
            // Idle: no period in flight, so a legal step loads at once.
            cnt_d = '0;
            if (accept && legal) step_d = cfg.cfg_step;
        end else begin
            if (boundary) begin
                cnt_d = '0;
                if (pvld_q) begin
                    step_d = pend_q;
                    pvld_d = 1'b0;
                end
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            // Evaluated after the swap: a step accepted on the boundary
            // cycle itself is held for the following boundary.
            if (accept && legal) begin
                pend_d = cfg.cfg_step;
                pvld_d = 1'b1;
            end
        end

        // Outputs are registered from the next-state view of the period.
        run_d    = state_d != IDLE;
        clkout_d = run_d && (cnt_d < (step_d >> 1));
        tick_d   = run_d && (cnt_d == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            step_q   <= DEFAULT_STEP;
            pend_q   <= '0;
            pvld_q   <= 1'b0;
            clkout_q <= 1'b0;
            tick_q   <= 1'b0;
            run_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            step_q   <= step_d;
            pend_q   <= pend_d;
            pvld_q   <= pvld_d;
            clkout_q <= clkout_d;
            tick_q   <= tick_d;
            run_q    <= run_d;
            err_q    <= err_d;
        end
    end

endmodule
